// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path: load/store opcodes,
// arbiter FSM states and a store-detect helper.
package riscv_mem_pkg;

  localparam logic [2:0] LB   = 3'b000;
  localparam logic [2:0] LHW  = 3'b001;
  localparam logic [2:0] LW   = 3'b010;
  localparam logic [2:0] SB   = 3'b011;
  localparam logic [2:0] SHW  = 3'b100;
  localparam logic [2:0] SW   = 3'b101;
  localparam logic [2:0] LBU  = 3'b110;
  localparam logic [2:0] LHWU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic is_store(input logic [2:0] opcode);
    return (opcode == SB) || (opcode == SHW) || (opcode == SW);
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Two-way grant logic, bit 0 = IF, bit 1 = LS. Fixed LS priority by default;
// round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arb_grant (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  // Remembers who won last; reset to IF so LS takes the first contention.
  logic last_ls;

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      case (req)
        2'b11:   gnt = last_ls ? 2'b01 : 2'b10;
        2'b10:   gnt = 2'b10;
        2'b01:   gnt = 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_ls <= 1'b0;
    else if (|gnt)
      last_ls <= gnt[1];
  end
`else
  logic unused_rr;
  assign unused_rr = clk ^ rst;

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      gnt[1] = req[1];
      gnt[0] = req[0] & ~req[1];
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between IF (read-only) and LS requesters.
// Arbitration policy selected by DMEM_ARB_RR_EN (round-robin when defined).
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int RD_LAT = 3,
  parameter int AW     = 12,
  parameter int DW     = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic [2:0]    ls_opcode,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_rsp_valid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_stall,
  output logic [2:0]    mem_opcode,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       owner_ls;
  logic       accept;
  logic [1:0] gnt;

  // Grants are only handed out in IDLE and never while reset is asserted.
  assign accept = (state == IDLE) && !RST;

  dmem_arb_grant u_grant (
    .clk    (CLK),
    .rst    (RST),
    .req    ({ls_req_valid, if_req_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign if_req_ready = gnt[0];
  assign ls_req_ready = gnt[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      owner_ls     <= 1'b0;
      mem_stall    <= 1'b1;
      mem_opcode   <= LW;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt[1]) begin
            owner_ls   <= 1'b1;
            mem_opcode <= ls_opcode;
            mem_addr   <= ls_addr;
            mem_wdata  <= ls_wdata;
            mem_stall  <= 1'b0;
            state      <= ISSUE;
          end else if (gnt[0]) begin
            owner_ls   <= 1'b0;
            mem_opcode <= LW;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_stall  <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          // Memory data is valid in the cycle the counter reaches zero.
          if (wait_cnt == 3'd0) begin
            mem_stall <= 1'b1;
            state     <= RESP;
            if (owner_ls) begin
              ls_rsp_valid <= 1'b1;
              ls_rdata     <= is_store(mem_opcode) ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rdata     <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (RD_LAT=3); contention
// expectations follow DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;
  import riscv_mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [11:0] if_addr;
  logic [31:0] if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_rsp_valid;
  logic [2:0]  ls_opcode;
  logic [11:0] ls_addr;
  logic [31:0] ls_wdata, ls_rdata;
  logic        mem_stall;
  logic [2:0]  mem_opcode;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int check_count = 0;
  int error_count = 0;
  int cyc = 0;
  int start_cyc;
  int grant_cyc[$];
  logic grant_ls[$];

  dmem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_opcode(ls_opcode),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_stall(mem_stall), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every grant mid-cycle so spacing and order can be checked afterwards.
  always @(negedge CLK) begin
    if (!RST) begin
      if (if_req_ready) begin grant_cyc.push_back(cyc); grant_ls.push_back(1'b0); end
      if (ls_req_ready) begin grant_cyc.push_back(cyc); grant_ls.push_back(1'b1); end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [11:0] ia, input logic lv,
                               input logic [2:0] lop, input logic [11:0] la,
                               input logic [31:0] lw, input logic [31:0] rd);
    if_req_valid = iv;  if_addr  = ia;
    ls_req_valid = lv;  ls_opcode = lop; ls_addr = la; ls_wdata = lw;
    mem_rdata    = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    grant_cyc.delete();
    grant_ls.delete();
  endtask

  logic exp_ls[4];

  initial begin
    applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #2;
    checkOutput("rst_mem_stall", 32'(mem_stall), 32'd1);
    checkOutput("rst_mem_opcode", 32'(mem_opcode), 32'(LW));
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_rsp_valid", 32'({if_rsp_valid, ls_rsp_valid}), 32'h0);
    checkOutput("rst_rdata", if_rdata | ls_rdata, 32'h0);
    checkOutput("rst_ready", 32'({if_req_ready, ls_req_ready}), 32'h0);

    // IF-only read
    do_reset();
    applyStimulus(1'b1, 12'h010, 1'b0, LW, 12'h0, 32'h0, 32'hDEADBEEF);
    checkOutput("if_ready_c0", 32'(if_req_ready), 32'd1);
    checkOutput("ls_ready_c0", 32'(ls_req_ready), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'hDEADBEEF);
      if (c <= 3) begin
        checkOutput($sformatf("if_stall_c%0d", c), 32'(mem_stall), 32'd0);
        checkOutput($sformatf("if_opcode_c%0d", c), 32'(mem_opcode), 32'(LW));
        checkOutput($sformatf("if_addr_c%0d", c), 32'(mem_addr), 32'h010);
      end
      checkOutput($sformatf("if_rsp_c%0d", c), 32'(if_rsp_valid), 32'(c == 5));
      if (c >= 5) checkOutput($sformatf("if_rdata_c%0d", c), if_rdata, 32'hDEADBEEF);
      if (c == 6) checkOutput("if_stall_c6", 32'(mem_stall), 32'd1);
    end

    // Reset mid-WAIT, then an LS load in the first free IDLE cycle
    do_reset();
    applyStimulus(1'b1, 12'h020, 1'b0, LW, 12'h0, 32'h0, 32'hCAFEF00D);
    checkOutput("rw_if_ready_c0", 32'(if_req_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'hCAFEF00D);
    tick();
    RST = 1'b1;
    applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'hCAFEF00D);
    checkOutput("rw_stall_c2", 32'(mem_stall), 32'd0);
    tick();
    RST = 1'b0;
    applyStimulus(1'b0, 12'h0, 1'b1, LW, 12'h055, 32'h0, 32'hCAFEF00D);
    checkOutput("rw_stall_c3", 32'(mem_stall), 32'd1);
    checkOutput("rw_addr_c3", 32'(mem_addr), 32'h0);
    checkOutput("rw_ls_ready_c3", 32'(ls_req_ready), 32'd1);
    checkOutput("rw_if_rsp_c3", 32'(if_rsp_valid), 32'd0);
    for (int c = 4; c <= 8; c++) begin
      tick();
      applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'hCAFEF00D);
      checkOutput($sformatf("rw_if_rsp_c%0d", c), 32'(if_rsp_valid), 32'd0);
      checkOutput($sformatf("rw_ls_rsp_c%0d", c), 32'(ls_rsp_valid), 32'(c == 8));
      if (c == 4) checkOutput("rw_addr_c4", 32'(mem_addr), 32'h055);
      if (c == 8) checkOutput("rw_ls_rdata_c8", ls_rdata, 32'hCAFEF00D);
    end

    // LS store: ls_rdata must return to zero despite live mem_rdata
    tick();
    applyStimulus(1'b0, 12'h0, 1'b1, SB, 12'h403, 32'h000000AA, 32'h12345678);
    checkOutput("st_ready_c0", 32'(ls_req_ready), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'h12345678);
      if (c <= 5) begin
        checkOutput($sformatf("st_opcode_c%0d", c), 32'(mem_opcode), 32'(SB));
        checkOutput($sformatf("st_addr_c%0d", c), 32'(mem_addr), 32'h403);
        checkOutput($sformatf("st_wdata_c%0d", c), mem_wdata, 32'h000000AA);
      end
      if (c <= 3) checkOutput($sformatf("st_stall_c%0d", c), 32'(mem_stall), 32'd0);
      checkOutput($sformatf("st_rsp_c%0d", c), 32'(ls_rsp_valid), 32'(c == 5));
      if (c == 5) checkOutput("st_rdata_c5", ls_rdata, 32'h0);
    end

    // Back-to-back IF with valid held
    do_reset();
    start_cyc = cyc;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      applyStimulus(1'b1, 12'h030, 1'b0, LW, 12'h0, 32'h0, 32'h0BADF00D);
    end
    tick();
    applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'h0);
    repeat (6) tick();
    checkOutput("b2b_grants", 32'(grant_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("b2b_cyc%0d", i), 32'(grant_cyc[i] - start_cyc), 32'(6 * i));
      checkOutput($sformatf("b2b_who%0d", i), 32'(grant_ls[i]), 32'd0);
    end

    // Contention: both held, LS drops valid at c18
`ifdef DMEM_ARB_RR_EN
    exp_ls = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    do_reset();
    start_cyc = cyc;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick();
      applyStimulus(1'b1, 12'h040, (c < 18), LW, 12'h100, 32'h0, 32'h11112222);
    end
    tick();
    applyStimulus(1'b0, 12'h0, 1'b0, LW, 12'h0, 32'h0, 32'h0);
    repeat (6) tick();
    checkOutput("cont_grants", 32'(grant_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("cont_cyc%0d", i), 32'(grant_cyc[i] - start_cyc), 32'(6 * i));
      checkOutput($sformatf("cont_who%0d", i), 32'(grant_ls[i]), 32'(exp_ls[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
